// File: rtl/h_encoder_12_7_stream.sv
// rtl/h_encoder_12_7_stream.sv - streaming SECDED Hamming(12,7) encoder with skid buffer
//
// Purpose:
//   Encodes 7-bit data words into 12-bit SECDED codewords (Hamming(11,7) plus
//   an overall parity bit in CW[11]), bit-compatible with h_decoder_11_7.
//   An output register and a one-entry skid register give one word per cycle
//   while keeping o_Ready a registered-flag function (no combinational path
//   from i_Ready to o_Ready).
//
// Optional feature macro: H_ENC_ERR_INJ_EN
//   Defined   : the stored codeword is encode(i_DataWord) ^ i_InjMask.
//   Undefined : i_InjMask is ignored and the codeword is always clean.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_DataWord   data word D[6:0]
//   i_Valid      upstream data valid
//   o_Ready      encoder can accept a word this cycle
//   o_CodeWord   encoded codeword
//   o_Valid      o_CodeWord valid
//   i_Ready      downstream accepts o_CodeWord this cycle
//   o_WordCount  codewords handed off downstream, mod 2^COUNT_W
//   i_InjMask    error-injection XOR mask (optional feature only)

module h_encoder_12_7_stream #(
  parameter int COUNT_W = 16
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [6:0]         i_DataWord,
  input  logic               i_Valid,
  output logic               o_Ready,
  output logic [11:0]        o_CodeWord,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [COUNT_W-1:0] o_WordCount,
  input  logic [11:0]        i_InjMask
);

  // CW[k-1] holds Hamming position k; parity bits sit at positions 1,2,4,8.
  function automatic logic [11:0] encode(input logic [6:0] d);
    logic [11:0] cw;
    cw      = '0;
    cw[2]   = d[0];
    cw[4]   = d[1];
    cw[5]   = d[2];
    cw[6]   = d[3];
    cw[8]   = d[4];
    cw[9]   = d[5];
    cw[10]  = d[6];
    cw[0]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    cw[1]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    cw[3]   = d[1] ^ d[2] ^ d[3];
    cw[7]   = d[4] ^ d[5] ^ d[6];
    cw[11]  = ^cw[10:0];
    return cw;
  endfunction

  logic               out_vld_q, out_vld_d;
  logic [11:0]        out_cw_q, out_cw_d;
  logic               skid_vld_q, skid_vld_d;
  logic [11:0]        skid_cw_q, skid_cw_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic        accept;
  logic        emit;
  logic [11:0] enc_word;

`ifdef H_ENC_ERR_INJ_EN
  assign enc_word = encode(i_DataWord) ^ i_InjMask;
`else
  logic unused_inj_mask;
  assign unused_inj_mask = ^i_InjMask;
  assign enc_word        = encode(i_DataWord);
`endif

  // Ready depends only on the registered skid flag (and reset), so an
  // accept can never collide with a full skid buffer.
  assign o_Ready = !skid_vld_q && !i_Reset;
  assign accept  = i_Valid && o_Ready;
  assign emit    = out_vld_q && i_Ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_cw_d   = out_cw_q;
    skid_vld_d = skid_vld_q;
    skid_cw_d  = skid_cw_q;
    count_d    = count_q + {{(COUNT_W-1){1'b0}}, emit};

    if (emit) begin
      if (skid_vld_q) begin
        out_cw_d   = skid_cw_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d  = 1'b0;
      end
    end

    // accept implies skid was empty at the start of the cycle, so the
    // skid-to-output move above and this load never target the same slot.
    if (accept) begin
      if (!out_vld_q || emit) begin
        out_vld_d = 1'b1;
        out_cw_d  = enc_word;
      end else begin
        skid_vld_d = 1'b1;
        skid_cw_d  = enc_word;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      out_vld_q  <= 1'b0;
      out_cw_q   <= '0;
      skid_vld_q <= 1'b0;
      skid_cw_q  <= '0;
      count_q    <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_cw_q   <= out_cw_d;
      skid_vld_q <= skid_vld_d;
      skid_cw_q  <= skid_cw_d;
      count_q    <= count_d;
    end
  end

  assign o_Valid     = out_vld_q;
  assign o_CodeWord  = out_cw_q;
  assign o_WordCount = count_q;

endmodule

// File: tb/tb_h_encoder_12_7_stream.sv
// tb/tb_h_encoder_12_7_stream.sv - scoreboard bench for h_encoder_12_7_stream
module tb_h_encoder_12_7_stream;

`ifdef H_ENC_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic [6:0]  i_DataWord = '0;
  logic        i_Valid = 1'b0;
  logic        i_Ready = 1'b0;
  logic [11:0] i_InjMask = '0;

  logic        o_Ready, o_Valid;
  logic [11:0] o_CodeWord;
  logic [15:0] o_WordCount;

  logic        w4_Ready, w4_Valid;
  logic [11:0] w4_CodeWord;
  logic [3:0]  w4_WordCount;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  h_encoder_12_7_stream #(.COUNT_W(16)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_DataWord(i_DataWord), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .o_CodeWord(o_CodeWord), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_WordCount(o_WordCount), .i_InjMask(i_InjMask)
  );

  h_encoder_12_7_stream #(.COUNT_W(4)) dut4 (
    .i_Clk(clk), .i_Reset(i_Reset), .i_DataWord(i_DataWord), .i_Valid(i_Valid),
    .o_Ready(w4_Ready), .o_CodeWord(w4_CodeWord), .o_Valid(w4_Valid), .i_Ready(i_Ready),
    .o_WordCount(w4_WordCount), .i_InjMask(i_InjMask)
  );

  // Generic Hamming construction: parity at 2^j covers positions with bit j set.
  function automatic logic [11:0] model_enc(input logic [6:0] d);
    logic [11:0] cw;
    int dpos[7];
    logic p;
    dpos = '{3, 5, 6, 7, 9, 10, 11};
    cw = '0;
    for (int i = 0; i < 7; i++) cw[dpos[i]-1] = d[i];
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int k = 1; k <= 11; k++) if ((k & (1 << j)) != 0) p ^= cw[k-1];
      cw[(1 << j) - 1] = p;
    end
    cw[11] = ^cw[10:0];
    return cw;
  endfunction

  // Drives one cycle of stimulus, samples 1 ns later, pushes expectations on accept.
  task automatic drive(input logic v, input logic [6:0] d, input logic rdy,
                       input logic [11:0] m, output logic acc, output logic em);
    @(negedge clk);
    i_Valid = v; i_DataWord = d; i_Ready = rdy; i_InjMask = m;
    #1;
    acc = v && o_Ready && !i_Reset;
    em  = o_Valid && rdy && !i_Reset;
    if (acc) sb.push_back(model_enc(d) ^ (INJ ? m : 12'h000));
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_Reset = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0;
    @(negedge clk);
    i_Reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++; if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_hi: got %b want 0", o_Ready); end
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_Valid); end
    n_checks++; if (o_CodeWord !== 12'h000) begin n_fail++; $display("FAIL reset_cw: got %h want 000", o_CodeWord); end
    n_checks++; if (o_WordCount !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_WordCount); end
    i_Reset = 1'b0;
    #1;
    n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", o_Ready); end
  endtask

  task automatic test_single();
    logic [6:0]  din[4];
    logic [11:0] want[4];
    logic acc, em;
    logic [11:0] exp;
    din  = '{7'h00, 7'h01, 7'h40, 7'h7F};
    want = '{12'h000, 12'h807, 12'h483, 12'hFFF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, din[i], 1'b1, 12'h000, acc, em);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept[%0d]: got %b want 1", i, acc); end
      drive(1'b0, 7'h55, 1'b1, 12'h000, acc, em);
      n_checks++; if (em !== 1'b1) begin n_fail++; $display("FAIL single_latency[%0d]: valid %b want 1", i, o_Valid); end
      if (em) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
        n_checks++; if (o_CodeWord !== want[i]) begin n_fail++; $display("FAIL single_cw[%0d]: got %h want %h", i, o_CodeWord, want[i]); end
        n_checks++; if (o_CodeWord !== exp) begin n_fail++; $display("FAIL single_sb[%0d]: got %h want %h", i, o_CodeWord, exp); end
      end
    end
    drive(1'b0, 7'h00, 1'b1, 12'h000, acc, em);
    n_checks++; if (o_WordCount !== 16'd4) begin n_fail++; $display("FAIL single_count: got %0d want 4", o_WordCount); end
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b want 0", o_Valid); end
  endtask

  task automatic test_back_to_back();
    logic acc, em;
    logic [11:0] exp;
    int n_em = 0;
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      drive(i <= 16, 7'(i), 1'b1, 12'h000, acc, em);
      if (i <= 16) begin
        n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, o_Ready); end
      end
      if (i >= 2 && i <= 17) begin
        n_checks++; if (em !== 1'b1) begin n_fail++; $display("FAIL b2b_gap[%0d]: valid %b want 1", i, o_Valid); end
      end
      if (em) begin
        n_em++;
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got %h want none", o_CodeWord); end
        else begin
          exp = sb.pop_front();
          if (o_CodeWord !== exp) begin n_fail++; $display("FAIL b2b_cw: got %h want %h", o_CodeWord, exp); end
        end
      end
    end
    n_checks++; if (o_WordCount !== 16'd16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", o_WordCount); end
    n_checks++; if (n_em != 16) begin n_fail++; $display("FAIL b2b_emits: got %0d want 16", n_em); end
  endtask

  task automatic test_stall();
    logic acc, em;
    logic [11:0] exp;
    do_reset();
    drive(1'b1, 7'h01, 1'b0, 12'h000, acc, em);
    drive(1'b1, 7'h40, 1'b0, 12'h000, acc, em);
    for (int i = 0; i < 3; i++) begin
      // Offered word must be refused while the skid is full.
      drive(1'b1, 7'h2A, 1'b0, 12'h000, acc, em);
      n_checks++; if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, o_Ready); end
      n_checks++; if (o_Valid !== 1'b1 || o_CodeWord !== 12'h807) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b cw=%h want v=1 cw=807", i, o_Valid, o_CodeWord); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'h00, 1'b1, 12'h000, acc, em);
      if (i < 2) begin
        n_checks++; if (em !== 1'b1) begin n_fail++; $display("FAIL stall_drain_gap[%0d]: valid %b want 1", i, o_Valid); end
      end
      if (em) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
        n_checks++; if (o_CodeWord !== exp) begin n_fail++; $display("FAIL stall_drain[%0d]: got %h want %h", i, o_CodeWord, exp); end
        n_checks++; if (o_CodeWord !== ((i == 0) ? 12'h807 : 12'h483)) begin
          n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", i, o_CodeWord, (i == 0) ? 12'h807 : 12'h483); end
      end
      if (i >= 1) begin
        n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after[%0d]: got %b want 1", i, o_Ready); end
      end
    end
    n_checks++; if (o_WordCount !== 16'd2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", o_WordCount); end
  endtask

  task automatic test_reset_mid();
    logic acc, em;
    do_reset();
    drive(1'b1, 7'h7F, 1'b1, 12'h000, acc, em);
    drive(1'b1, 7'h01, 1'b0, 12'h000, acc, em);
    drive(1'b1, 7'h40, 1'b0, 12'h000, acc, em);
    drive(1'b0, 7'h00, 1'b0, 12'h000, acc, em);
    n_checks++; if (o_Ready !== 1'b0 || o_Valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_full: got ready=%b valid=%b want 0/1", o_Ready, o_Valid); end
    @(negedge clk);
    i_Reset = 1'b1; i_Ready = 1'b1;
    #1;
    n_checks++; if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_hi: got %b want 0", o_Ready); end
    @(negedge clk);
    i_Reset = 1'b0; i_Ready = 1'b0;
    sb.delete();
    #1;
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", o_Valid); end
    n_checks++; if (o_CodeWord !== 12'h000) begin n_fail++; $display("FAIL rmid_cw: got %h want 000", o_CodeWord); end
    n_checks++; if (o_WordCount !== 16'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", o_WordCount); end
    n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after: got %b want 1", o_Ready); end
    // Nothing from before reset may surface afterwards.
    drive(1'b0, 7'h00, 1'b1, 12'h000, acc, em);
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got valid=%b cw=%h want 0", o_Valid, o_CodeWord); end
  endtask

  task automatic test_count_wrap();
    logic acc, em;
    logic [11:0] exp;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      drive(c < 17, 7'(c * 5 + 3), 1'b1, 12'h000, acc, em);
      if (c == 16) begin
        n_checks++; if (w4_WordCount !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", w4_WordCount); end
      end
      if (c == 17) begin
        n_checks++; if (w4_WordCount !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d want 0", w4_WordCount); end
      end
      if (c == 18) begin
        n_checks++; if (w4_WordCount !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d want 1", w4_WordCount); end
        n_checks++; if (o_WordCount !== 16'd17) begin n_fail++; $display("FAIL wrap_wide: got %0d want 17", o_WordCount); end
      end
      if (em) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
        n_checks++; if (o_CodeWord !== exp) begin n_fail++; $display("FAIL wrap_cw[%0d]: got %h want %h", c, o_CodeWord, exp); end
      end
    end
  endtask

  task automatic test_inject();
    logic acc, em;
    logic [11:0] exp, m;
    logic [6:0]  d;
    do_reset();
    for (int i = 0; i <= 12; i++) begin
`ifdef H_ENC_ERR_INJ_EN
      d = 7'h00;
      m = (i < 12) ? (12'h001 << i) : 12'h003;
`else
      d = 7'($urandom_range(0, 127));
      m = 12'($urandom_range(1, 4095));
`endif
      drive(1'b1, d, 1'b1, m, acc, em);
      drive(1'b0, 7'h00, 1'b1, 12'h000, acc, em);
      n_checks++;
      if (!em || sb.size() == 0) begin n_fail++; $display("FAIL inj_missing[%0d]: valid %b want 1", i, o_Valid); end
      else begin
        exp = sb.pop_front();
        if (o_CodeWord !== exp) begin n_fail++; $display("FAIL inj_cw[%0d]: got %h want %h", i, o_CodeWord, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_count_wrap();
    test_inject();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/h_encoder_12_7_stream.md
Name: h_encoder_12_7_stream

Overview:
- Streaming SECDED Hamming(12,7) encoder; the transmit-side counterpart of h_decoder_11_7.
- Accepts 7-bit data words on a valid/ready handshake and emits 12-bit codewords, bit-compatible with the decoder: Hamming(11,7) plus an overall parity bit.
- One output register plus a one-entry skid buffer give full throughput with registered backpressure.
- Sits between a data producer and the channel or storage that feeds the decoder.

Parameters:
- COUNT_W, 16, width of the emitted-codeword counter o_WordCount.

Ports:
- i_Clk  input  1  clock; all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_DataWord  input  7  data word D[6:0].
- i_Valid  input  1  upstream asserts i_DataWord valid.
- o_Ready  output  1  encoder can accept a word this cycle.
- o_CodeWord  output  12  encoded codeword.
- o_Valid  output  1  o_CodeWord valid.
- i_Ready  input  1  downstream accepts o_CodeWord this cycle.
- o_WordCount  output  COUNT_W  number of codewords handed off downstream (mod 2^COUNT_W).
- i_InjMask  input  12  error-injection XOR mask; used only with the optional feature.

Behaviour:
- Codeword layout: CW[k-1] = Hamming position k, for k = 1..11.
- Data placement: D0..D6 go to CW[2], CW[4], CW[5], CW[6], CW[8], CW[9], CW[10].
- Parity bits:
  - CW[0] = D0^D1^D3^D4^D6
  - CW[1] = D0^D2^D3^D5^D6
  - CW[3] = D1^D2^D3
  - CW[7] = D4^D5^D6
  - CW[11] = XOR of CW[10:0] (overall parity)
- Accept event: i_Valid && o_Ready. Emit event: o_Valid && i_Ready.
- Latency: a word accepted in cycle N appears on o_CodeWord/o_Valid in cycle N+1, when the output stage is free or draining.
- Storage: output register OUT and skid register SKID, each holding {vld, cw}.
- o_Ready = !SKID.vld && !i_Reset, derived from a registered flag.
- On accept, if (!OUT.vld || emit) and !SKID.vld: OUT loads the encoded word.
- On accept otherwise: SKID loads the encoded word. At most one word is held in SKID.
- On emit with SKID.vld: OUT loads SKID, and SKID clears.
  - A simultaneous accept then fills SKID only if it was empty; o_Ready = 0 guarantees this.
- On emit with no new data: OUT.vld clears.
- Ordering is strictly FIFO; words are never dropped or duplicated.
- Hold rule: while o_Valid && !i_Ready, o_CodeWord and o_Valid stay stable.
- o_WordCount increments by 1 on each emit and wraps from 2^COUNT_W-1 to 0.
- Reset (any cycle, including mid-stream or while stalled):
  - Next cycle: o_Valid=0, o_CodeWord=0, o_WordCount=0; SKID and OUT are cleared.
  - o_Ready=0 while i_Reset is high and 1 in the first cycle after deassertion.
  - In-flight words are discarded.
- i_DataWord is ignored when no accept occurs. Encoding is purely combinational before the register; no extra pipeline stage.

Optional Feature:
- Macro: H_ENC_ERR_INJ_EN.
- Defined: the codeword loaded into OUT or SKID is encode(i_DataWord) ^ i_InjMask, sampled in the accept cycle. Used to drive single- and double-bit errors into h_decoder_11_7.
- Undefined: i_InjMask is ignored (no logic), and the output is always the clean codeword.

Test Plan:
- Reset, then one word at a time with i_Ready=1:
  - 7'h00 -> 12'h000
  - 7'h01 -> 12'h807
  - 7'h40 -> 12'h483
  - 7'h7F -> 12'hFFF
  - Each appears one cycle after accept; o_WordCount=4 at the end.
- Back-to-back stream of 7'h01..7'h10, i_Valid and i_Ready held high -> one codeword per cycle in order, o_Ready stays 1, o_WordCount=16.
- Stall: i_Ready=0 while sending 7'h01 then 7'h40 -> OUT holds 12'h807, SKID holds 12'h483, o_Ready=0. Raise i_Ready -> 12'h807, then 12'h483 on consecutive cycles, then o_Ready=1.
- Assert i_Reset for 1 cycle while OUT and SKID are full -> next cycle o_Valid=0, o_CodeWord=0, o_WordCount=0; o_Ready=1 one cycle after deassertion.
- COUNT_W=4: emit 17 words -> o_WordCount reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- With H_ENC_ERR_INJ_EN, data 7'h00, i_InjMask=1<<i for i=0..11 -> o_CodeWord = 1<<i. Fed to h_decoder_11_7, this gives o_ErrorC=1, o_ErrorD=0 and DW=0. Mask 12'h003 -> o_ErrorD=1.
